c2h_stream_gen: RTL and testbench



---
 rtl/c2h_stream_gen_pkg.sv | 41 ++++
 rtl/c2h_stream_gen.sv | 147 ++++++++++++++
 tb/tb_c2h_stream_gen.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/c2h_stream_gen_pkg.sv
// c2h_stream_gen_pkg
// Shared types and helpers for the synthetic C2H frame source.
//   c2h_gen_state_t : two-state frame FSM (IDLE, SEND).
//   last_keep()     : tkeep mask for the final beat of a frame.
//   lane_word()     : 32-bit pattern word for one lane of one beat.
package c2h_stream_gen_pkg;

  // Widest tkeep supported by last_keep(); covers data widths up to 1024 bits.
  localparam int unsigned MaxKeep = 128;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } c2h_gen_state_t;

  // Low (len mod bpb) bits set, or the full bpb bits when len is a whole number of beats.
  function automatic logic [MaxKeep-1:0] last_keep(input logic [63:0] len,
                                                   input int unsigned bpb);
    logic [63:0]        r;
    int unsigned        n;
    logic [MaxKeep-1:0] m;
    r = len % 64'(bpb);
    n = (r == 64'd0) ? bpb : 32'(r);
    m = '0;
    for (int unsigned i = 0; i < MaxKeep; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

  // seed + beat*lanes + lane, modulo 2^32.
  function automatic logic [31:0] lane_word(input logic [31:0] seed,
                                            input logic [63:0] beat,
                                            input int unsigned lane,
                                            input int unsigned lanes);
    logic [63:0] s;
    s = {32'd0, seed} + beat * 64'(lanes) + 64'(lane);
    return s[31:0];
  endfunction

endpackage

// File: rtl/c2h_stream_gen.sv
// c2h_stream_gen
// Synthetic AXI-Stream frame source for the XDMA card-to-host channel. Each accepted
// command (byte length + seed) produces one packet of incrementing 32-bit words with
// tkeep trimmed and tlast set on the final beat. All outputs are registered.
// Ports:
//   axi_clk, axi_rst           : clock, synchronous active-high reset
//   cmd_valid/cmd_ready        : command handshake; cmd_len (bytes), cmd_seed (first word)
//   m_axis_c2h_t*              : AXI-Stream master towards XDMA s_axis_c2h_*_0
//   busy                       : frame in progress
//   frames_sent                : completed frames (tlast handshakes), wraps
module c2h_stream_gen
  import c2h_stream_gen_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = 128,
  parameter int unsigned LEN_WIDTH    = 32
) (
  input  logic                      axi_clk,
  input  logic                      axi_rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [LEN_WIDTH-1:0]      cmd_len,
  input  logic [31:0]               cmd_seed,
  output logic [C_DATA_WIDTH-1:0]   m_axis_c2h_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_c2h_tkeep,
  output logic                      m_axis_c2h_tlast,
  output logic                      m_axis_c2h_tvalid,
  input  logic                      m_axis_c2h_tready,
  output logic                      busy,
  output logic [31:0]               frames_sent
);

  localparam int unsigned BPB = C_DATA_WIDTH / 8;
  localparam int unsigned L   = C_DATA_WIDTH / 32;

  localparam logic [LEN_WIDTH-1:0] BpbL = LEN_WIDTH'(BPB);
  localparam logic [LEN_WIDTH-1:0] OneL = LEN_WIDTH'(1);

  c2h_gen_state_t       state_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] beat_q;
  logic [LEN_WIDTH-1:0] last_idx_q;
  logic [31:0]          seed_q;

  logic                 cmd_fire;
  logic                 beat_fire;
  logic [LEN_WIDTH-1:0] cmd_last_idx;

  // Contents of the beat to be loaded into the output registers next: beat 0 of the
  // incoming command while idle, otherwise the beat after the current one.
  logic [31:0]          gen_seed;
  logic [LEN_WIDTH-1:0] gen_beat;
  logic [LEN_WIDTH-1:0] gen_len;
  logic [LEN_WIDTH-1:0] gen_last_idx;
  logic                 gen_is_last;
  logic [MaxKeep-1:0]   keep_full;
  logic [BPB-1:0]       gen_keep;
  logic [C_DATA_WIDTH-1:0] gen_data;
  logic [31:0]          lane_w [L];

  always_comb begin
    cmd_fire     = (state_q == IDLE) && cmd_valid && cmd_ready;
    beat_fire    = (state_q == SEND) && m_axis_c2h_tready;
    cmd_last_idx = (cmd_len - OneL) / BpbL;

    if (state_q == IDLE) begin
      gen_seed     = cmd_seed;
      gen_beat     = '0;
      gen_len      = cmd_len;
      gen_last_idx = cmd_last_idx;
    end else begin
      gen_seed     = seed_q;
      gen_beat     = beat_q + OneL;
      gen_len      = len_q;
      gen_last_idx = last_idx_q;
    end

    gen_is_last = (gen_beat == gen_last_idx);
    keep_full   = last_keep(64'(gen_len), BPB);
    gen_keep    = gen_is_last ? keep_full[BPB-1:0] : '1;
  end

  // Per-lane pattern words; bytes outside tkeep are forced to zero.
  for (genvar i = 0; i < L; i++) begin : g_lane
    assign lane_w[i] = lane_word(gen_seed, 64'(gen_beat), i, L);
    for (genvar b = 0; b < 4; b++) begin : g_byte
      assign gen_data[32*i+8*b +: 8] = gen_keep[4*i+b] ? lane_w[i][8*b +: 8] : 8'h00;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state_q           <= IDLE;
      len_q             <= '0;
      beat_q            <= '0;
      last_idx_q        <= '0;
      seed_q            <= '0;
      cmd_ready         <= 1'b0;
      m_axis_c2h_tdata  <= '0;
      m_axis_c2h_tkeep  <= '0;
      m_axis_c2h_tlast  <= 1'b0;
      m_axis_c2h_tvalid <= 1'b0;
      busy              <= 1'b0;
      frames_sent       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cmd_ready <= 1'b1;
          // A zero-length command is consumed without leaving IDLE.
          if (cmd_fire && (cmd_len != '0)) begin
            state_q           <= SEND;
            len_q             <= cmd_len;
            seed_q            <= cmd_seed;
            beat_q            <= '0;
            last_idx_q        <= cmd_last_idx;
            cmd_ready         <= 1'b0;
            busy              <= 1'b1;
            m_axis_c2h_tvalid <= 1'b1;
            m_axis_c2h_tdata  <= gen_data;
            m_axis_c2h_tkeep  <= gen_keep;
            m_axis_c2h_tlast  <= gen_is_last;
          end
        end
        SEND: begin
          if (beat_fire) begin
            if (m_axis_c2h_tlast) begin
              state_q           <= IDLE;
              cmd_ready         <= 1'b1;
              busy              <= 1'b0;
              m_axis_c2h_tvalid <= 1'b0;
              m_axis_c2h_tdata  <= '0;
              m_axis_c2h_tkeep  <= '0;
              m_axis_c2h_tlast  <= 1'b0;
              frames_sent       <= frames_sent + 32'd1;
            end else begin
              beat_q           <= gen_beat;
              m_axis_c2h_tdata <= gen_data;
              m_axis_c2h_tkeep <= gen_keep;
              m_axis_c2h_tlast <= gen_is_last;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c2h_stream_gen.sv
module tb_c2h_stream_gen;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [31:0]  cmd_len = '0;
  logic [31:0]  cmd_seed = '0;
  logic [127:0] tdata;
  logic [15:0]  tkeep;
  logic         tlast;
  logic         tvalid;
  logic         tready = 1'b0;
  logic         busy;
  logic [31:0]  frames_sent;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_frames = '0;

  always #5 clk = ~clk;

  c2h_stream_gen #(
    .C_DATA_WIDTH(128),
    .LEN_WIDTH   (32)
  ) dut (
    .axi_clk          (clk),
    .axi_rst          (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_len          (cmd_len),
    .cmd_seed         (cmd_seed),
    .m_axis_c2h_tdata (tdata),
    .m_axis_c2h_tkeep (tkeep),
    .m_axis_c2h_tlast (tlast),
    .m_axis_c2h_tvalid(tvalid),
    .m_axis_c2h_tready(tready),
    .busy             (busy),
    .frames_sent      (frames_sent)
  );

  typedef struct {
    logic [31:0]  len;
    logic [31:0]  seed;
    int           nbeats;
    logic [127:0] d0;
    logic [15:0]  k0;
    logic         l0;
    logic [127:0] dl;
    logic [15:0]  kl;
    logic         ll;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference beat: lane i of beat k = seed + 4k + i; last beat keeps len - 16k bytes.
  task automatic exp_beat(input logic [31:0] seed, input logic [31:0] len, input int k,
                          output logic [127:0] d, output logic [15:0] kp, output logic lst);
    int nbeats;
    int nbytes;
    logic [31:0] word;
    nbeats = int'((len + 32'd15) / 32'd16);
    lst    = (k == nbeats - 1);
    nbytes = lst ? int'(len) - 16 * k : 16;
    d  = '0;
    kp = '0;
    for (int b = 0; b < 16; b++) begin
      word = seed + 32'(k * 4 + b / 4);
      kp[b] = (b < nbytes);
      if (b < nbytes) d[8*b +: 8] = word[8*(b%4) +: 8];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    tready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tkeep", tkeep, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frames", frames_sent, 0);
    exp_frames = '0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
  endtask

  // Presents a command from a negedge; returns at the negedge after the handshake edge.
  task automatic send_cmd(input logic [31:0] len, input logic [31:0] seed);
    int w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_seed  = seed;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_len   = 32'hFFFF_FFFF;
    cmd_seed  = 32'hDEAD_BEEF;
  endtask

  // Drains one frame with tready bit c of pat in cycle c (1 after cycle 31).
  task automatic collect(input logic [31:0] seed, input logic [31:0] len, input logic [31:0] pat,
                         output int nhs, output logic [127:0] d0, output logic [15:0] k0,
                         output logic l0, output logic [127:0] dl, output logic [15:0] kl,
                         output logic ll);
    int cyc = 0;
    bit done = 0;
    bit stalled = 0;
    logic [127:0] hd, ed;
    logic [15:0]  hk, ek;
    logic         hl, el;
    nhs = 0;
    d0 = '0; k0 = '0; l0 = 1'b0; dl = '0; kl = '0; ll = 1'b0;
    hd = '0; hk = '0; hl = 1'b0;
    chk("busy_in_frame", busy, 1);
    while (!done && cyc < 200) begin
      tready = (cyc < 32) ? pat[cyc] : 1'b1;
      if (stalled) begin
        chk("stall_tvalid", tvalid, 1);
        chk("stall_tdata", tdata, hd);
        chk("stall_tkeep", tkeep, hk);
        chk("stall_tlast", tlast, hl);
      end
      if (tvalid && tready) begin
        exp_beat(seed, len, nhs, ed, ek, el);
        chk("beat_tdata", tdata, ed);
        chk("beat_tkeep", tkeep, ek);
        chk("beat_tlast", tlast, el);
        if (nhs == 0) begin
          d0 = tdata; k0 = tkeep; l0 = tlast;
        end
        dl = tdata; kl = tkeep; ll = tlast;
        nhs++;
        if (tlast) done = 1;
      end
      stalled = tvalid && !tready;
      hd = tdata; hk = tkeep; hl = tlast;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    tready = 1'b0;
    if (!done) begin
      chk("frame_timeout", 0, 1);
    end else begin
      exp_frames = exp_frames + 32'd1;
      chk("frames_sent", frames_sent, exp_frames);
      chk("idle_tvalid", tvalid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_cmd_ready", cmd_ready, 1);
    end
  endtask

  int           nhs;
  logic [127:0] d0, dl, ed;
  logic [15:0]  k0, kl, ek;
  logic         l0, ll, el;

  initial begin
    vecs[0] = '{32'd64, 32'h0, 4,
                128'h00000003_00000002_00000001_00000000, 16'hFFFF, 1'b0,
                128'h0000000F_0000000E_0000000D_0000000C, 16'hFFFF, 1'b1};
    vecs[1] = '{32'd20, 32'h100, 2,
                128'h00000103_00000102_00000101_00000100, 16'hFFFF, 1'b0,
                128'h00000000_00000000_00000000_00000104, 16'h000F, 1'b1};
    vecs[2] = '{32'd16, 32'hFFFF_FFFE, 1,
                128'h00000001_00000000_FFFFFFFF_FFFFFFFE, 16'hFFFF, 1'b1,
                128'h00000001_00000000_FFFFFFFF_FFFFFFFE, 16'hFFFF, 1'b1};
    vecs[3] = '{32'd17, 32'h10, 2,
                128'h00000013_00000012_00000011_00000010, 16'hFFFF, 1'b0,
                128'h00000000_00000000_00000000_00000014, 16'h0001, 1'b1};
    vecs[4] = '{32'd31, 32'hAABB_CCDD, 2,
                128'hAABBCCE0_AABBCCDF_AABBCCDE_AABBCCDD, 16'hFFFF, 1'b0,
                128'h00BBCCE4_AABBCCE3_AABBCCE2_AABBCCE1, 16'h7FFF, 1'b1};
    vecs[5] = '{32'd1, 32'h1234_5678, 1,
                128'h00000000_00000000_00000000_00000078, 16'h0001, 1'b1,
                128'h00000000_00000000_00000000_00000078, 16'h0001, 1'b1};

    do_reset();

    // Table-driven frames at full throughput.
    for (int v = 0; v < 6; v++) begin
      send_cmd(vecs[v].len, vecs[v].seed);
      collect(vecs[v].seed, vecs[v].len, 32'hFFFF_FFFF, nhs, d0, k0, l0, dl, kl, ll);
      chk("vec_nbeats", nhs, vecs[v].nbeats);
      chk("vec_first_tdata", d0, vecs[v].d0);
      chk("vec_first_tkeep", k0, vecs[v].k0);
      chk("vec_first_tlast", l0, vecs[v].l0);
      chk("vec_last_tdata", dl, vecs[v].dl);
      chk("vec_last_tkeep", kl, vecs[v].kl);
      chk("vec_last_tlast", ll, vecs[v].ll);
    end

    // Back-pressure: tready 1,0,0,1,0,1,1,...
    send_cmd(32'd64, 32'h40);
    collect(32'h40, 32'd64, 32'hFFFF_FFE9, nhs, d0, k0, l0, dl, kl, ll);
    chk("stall_nbeats", nhs, 4);
    chk("stall_last_tdata", dl, 128'h0000004F_0000004E_0000004D_0000004C);

    // Zero-length command is consumed with no beat.
    send_cmd(32'd0, 32'h55);
    chk("zero_tvalid", tvalid, 0);
    chk("zero_cmd_ready", cmd_ready, 1);
    chk("zero_frames", frames_sent, exp_frames);
    repeat (2) begin
      @(negedge clk);
      chk("zero_tvalid_hold", tvalid, 0);
    end
    send_cmd(32'd16, 32'h900);
    collect(32'h900, 32'd16, 32'hFFFF_FFFF, nhs, d0, k0, l0, dl, kl, ll);
    chk("after_zero_nbeats", nhs, 1);
    chk("after_zero_tlast", ll, 1);

    // Reset in the middle of a frame.
    send_cmd(32'd64, 32'h500);
    tready = 1'b1;
    chk("mid_tvalid", tvalid, 1);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    exp_beat(32'h500, 32'd64, 2, ed, ek, el);
    chk("mid_beat2_tdata", tdata, ed);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tvalid", tvalid, 0);
    chk("midrst_frames", frames_sent, 0);
    chk("midrst_tlast", tlast, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    tready = 1'b0;
    exp_frames = '0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_release_cmd_ready", cmd_ready, 1);
    send_cmd(32'd16, 32'h777);
    collect(32'h777, 32'd16, 32'hFFFF_FFFF, nhs, d0, k0, l0, dl, kl, ll);
    chk("midrst_new_nbeats", nhs, 1);
    chk("midrst_new_tdata", d0, 128'h0000077A_00000779_00000778_00000777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
